br_dispatch_tx: RTL and testbench
=================================

Name: br_dispatch_tx

Overview:
Dispatch-side transmitter for the branch issue path. It buffers renamed branch/jump uops from rename/dispatch in a small in-order FIFO. It drives them to the branch reservation station over the mono dispatch valid/ready handshake. It sits between the dispatch arbiter and the branch RS, and decouples rename stalls from RS-full back-pressure.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), read/write pointer width (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- flush  in  1  backend flush (branch mispredict / exception); discards all buffered uops.
- in_valid  in  1  dispatch presents a branch uop.
- in_uop  in  $bits(uop_t)  renamed uop: rob_id, rs1/rs2_phy+valid, rd_phy, rd_arch, imm, pc, fu_opcode, predict_taken, predict_target.
- in_ready  out  1  buffer can accept a uop this cycle.
- rs_valid  out  1  uop offered to the branch RS.
- rs_uop  out  $bits(uop_t)  uop offered to the RS.
- rs_ready  in  1  RS has a free entry and branch path is ready.
- occupancy  out  PTR_W+1  number of buffered uops.

Behaviour:
- Storage is DEPTH entries of uop_t plus rd_ptr, wr_ptr (PTR_W bits, natural wrap) and count (PTR_W+1 bits).
- Reset (rst_n low, async): rd_ptr=0, wr_ptr=0, count=0. Outputs: in_ready=1, rs_valid=0, occupancy=0. rs_uop is don't-care; entry storage is not reset.
- push = in_valid & in_ready & ~flush. pop = rs_valid & rs_ready.
- in_ready = (count != DEPTH) & ~flush.
  - in_ready depends only on registered state and flush, never on rs_ready. There is no combinational ready path through the block.
  - When full, a same-cycle pop does not enable a push.
- rs_valid = (count != 0) & ~flush. rs_uop = entry[rd_ptr].
- Latency is 1 cycle: a uop pushed at edge N is first visible on rs_valid after edge N.
- Push writes entry[wr_ptr] and increments wr_ptr. Pop increments rd_ptr. count updates by +push −pop; a simultaneous push and pop leaves count unchanged.
- Once rs_valid is asserted, rs_valid and rs_uop stay stable until the pop or a flush.
- flush high at an edge: rd_ptr, wr_ptr and count go to 0. During the flush cycle rs_valid=0 and in_ready=0, so no uop crosses either interface.
- Pointer wrap: entries are reused modulo DEPTH. Order is strictly FIFO.
- occupancy = count (registered).
- A reset mid-transfer discards all state immediately. No partial handshake completes.

Optional Feature:
- Macro BR_DISPATCH_BYPASS_EN.
- Defined: when count==0, in_valid=1, rs_ready=1 and flush=0, in_uop is forwarded combinationally.
  - rs_valid=1 and rs_uop=in_uop in the same cycle.
  - The uop is not written to the FIFO and count stays 0. Latency is 0.
  - If rs_ready=0, the uop is pushed normally.
  - Here rs_valid is combinationally dependent on in_valid and rs_ready.
- Undefined: no bypass; latency is always exactly 1 cycle.

Decomposition:
- uop_t, bypass-independent constants and BR_DISPATCH_DEPTH default belong in cpu_params / uop_types.
- One natural sub-module: sync_fifo_ctrl, which holds the pointers, count, full and empty. It is reusable for the ALU and MEM dispatch transmitters.
- Storage array and flush gating stay in br_dispatch_tx.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, release → in_ready=1, rs_valid=0, occupancy=0. An async assert mid-cycle clears all three immediately.
- Basic order: push uops with rob_id 3,4,5 while rs_ready=0, then hold rs_ready=1 → rs_uop.rob_id sequence 3,4,5 on consecutive cycles; occupancy 3,2,1,0.
- Full back-pressure (DEPTH=4): push 4 uops with rs_ready=0 → in_ready=0. A 5th in_valid is ignored. Assert rs_ready for one cycle → count 3 and in_ready=1 next cycle.
- Simultaneous push/pop at count=2 with continuous traffic for 10 cycles → count stays 2. rob_id order is preserved across pointer wrap.
- Flush with 3 buffered uops and in_valid=1 → in that cycle rs_valid=0 and in_ready=0. Next cycle occupancy=0 and the incoming uop was not captured.
- With BR_DISPATCH_BYPASS_EN: empty, in_valid=1 rob_id=7, rs_ready=1 → same-cycle rs_valid=1, rs_uop.rob_id=7, occupancy stays 0. Without the macro, the same stimulus → rs_valid=1 one cycle later.

Source files
------------

// File: rtl/br_dispatch_tx_pkg.sv
// Shared types and defaults for the dispatch-side transmitters.
// Renamed uop layout and the default branch dispatch buffer depth.
package br_dispatch_tx_pkg;

  localparam int ROB_ID_W    = 6;
  localparam int PHY_REG_W   = 7;
  localparam int ARCH_REG_W  = 5;
  localparam int XLEN        = 32;
  localparam int FU_OPCODE_W = 4;

  localparam int BR_DISPATCH_DEPTH = 4;

  typedef struct packed {
    logic [ROB_ID_W-1:0]    rob_id;
    logic [PHY_REG_W-1:0]   rs1_phy;
    logic                   rs1_valid;
    logic [PHY_REG_W-1:0]   rs2_phy;
    logic                   rs2_valid;
    logic [PHY_REG_W-1:0]   rd_phy;
    logic [ARCH_REG_W-1:0]  rd_arch;
    logic [XLEN-1:0]        imm;
    logic [XLEN-1:0]        pc;
    logic [FU_OPCODE_W-1:0] fu_opcode;
    logic                   predict_taken;
    logic [XLEN-1:0]        predict_target;
  } uop_t;

endpackage

// File: rtl/br_dispatch_tx_sync_fifo_ctrl.sv
// Pointer/count bookkeeping for a synchronous in-order FIFO.
// Storage lives in the instantiating block; this only tracks positions.
module br_dispatch_tx_sync_fifo_ctrl #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

  // NOTE: sequential state is assigned with <= so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/br_dispatch_tx.sv
// Branch dispatch transmitter: in-order uop buffer towards the branch RS.
// Optional same-cycle bypass when empty, enabled by BR_DISPATCH_BYPASS_EN.
module br_dispatch_tx
  import br_dispatch_tx_pkg::*;
#(
  parameter int DEPTH = BR_DISPATCH_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           in_valid,
  input  uop_t           in_uop,
  output logic           in_ready,
  output logic           rs_valid,
  output uop_t           rs_uop,
  input  logic           rs_ready,
  output logic [PTR_W:0] occupancy
);

  uop_t             entry [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             bypass;
  logic             push;
  logic             pop;

  // Ready looks only at registered fullness and flush, never at rs_ready.
  assign in_ready = ~full & ~flush;

`ifdef BR_DISPATCH_BYPASS_EN
  assign bypass = empty & in_valid & rs_ready & ~flush;
`else
  assign bypass = 1'b0;
`endif

  // NOTE: every output of this block gets a default first so no path
  // through it can leave a value held, which would infer a latch.
  always_comb begin
    rs_valid = ~empty & ~flush;
    rs_uop   = entry[rd_ptr];
    if (bypass) begin
      rs_valid = 1'b1;
      rs_uop   = in_uop;
    end
  end

  assign push = in_valid & in_ready & ~flush & ~bypass;
  assign pop  = rs_valid & rs_ready & ~bypass;

  br_dispatch_tx_sync_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .push   (push),
    .pop    (pop),
    .rd_ptr (rd_ptr),
    .wr_ptr (wr_ptr),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // NOTE: payload storage has no reset; validity is tracked by count alone,
  // so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (push) entry[wr_ptr] <= in_uop;
  end

  assign occupancy = count;

endmodule

// File: tb/tb_br_dispatch_tx.sv
// Scoreboard bench for br_dispatch_tx: stimulus queues expected uops,
// a negedge monitor checks every RS handshake against the queue.
module tb_br_dispatch_tx;
  import br_dispatch_tx_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  uop_t       in_uop = '0;
  logic       in_ready;
  logic       rs_valid;
  uop_t       rs_uop;
  logic       rs_ready = 1'b0;
  logic [2:0] occupancy;

  int   n_tests = 0;
  int   n_fail  = 0;
  uop_t exp_q[$];

  br_dispatch_tx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_uop    (in_uop),
    .in_ready  (in_ready),
    .rs_valid  (rs_valid),
    .rs_uop    (rs_uop),
    .rs_ready  (rs_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic uop_t mk_uop(input logic [5:0] id);
    uop_t u;
    u                = '0;
    u.rob_id         = id;
    u.rs1_phy        = {1'b0, id};
    u.rs1_valid      = id[0];
    u.rs2_phy        = {1'b1, id};
    u.rs2_valid      = ~id[0];
    u.rd_phy         = {1'b0, ~id};
    u.rd_arch        = id[4:0];
    u.imm            = {26'h0, id} ^ 32'h0000_A5A5;
    u.pc             = 32'h0000_1000 + {24'h0, id, 2'b00};
    u.fu_opcode      = id[3:0];
    u.predict_taken  = id[1];
    u.predict_target = u.pc + u.imm;
    return u;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_uop(input logic [5:0] id);
    in_valid = 1'b1;
    in_uop   = mk_uop(id);
    exp_q.push_back(mk_uop(id));
    step();
    in_valid = 1'b0;
  endtask

  // Monitor: every completed RS handshake must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && rs_valid && rs_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rs_uop", {26'h0, rs_uop.rob_id}, 32'hFFFF_FFFF);
      end else begin
        uop_t e;
        e = exp_q.pop_front();
        check("rs_rob_id", {26'h0, rs_uop.rob_id}, {26'h0, e.rob_id});
        check("rs_uop_full", {31'h0, rs_uop == e}, 32'h1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for two cycles.
    step();
    step();
    check("reset_in_ready", {31'h0, in_ready}, 32'h1);
    check("reset_rs_valid", {31'h0, rs_valid}, 32'h0);
    check("reset_occupancy", {29'h0, occupancy}, 32'h0);
    rst_n = 1'b1;
    step();

    // Basic FIFO order.
    push_uop(6'd3);
    push_uop(6'd4);
    push_uop(6'd5);
    check("basic_occ3", {29'h0, occupancy}, 32'd3);
    rs_ready = 1'b1;
    step();
    check("basic_occ2", {29'h0, occupancy}, 32'd2);
    step();
    check("basic_occ1", {29'h0, occupancy}, 32'd1);
    step();
    check("basic_occ0", {29'h0, occupancy}, 32'd0);
    rs_ready = 1'b0;

    // Full back-pressure; the 5th uop must be ignored.
    push_uop(6'd6);
    push_uop(6'd7);
    push_uop(6'd8);
    push_uop(6'd9);
    check("full_in_ready", {31'h0, in_ready}, 32'h0);
    check("full_occ4", {29'h0, occupancy}, 32'd4);
    in_valid = 1'b1;
    in_uop   = mk_uop(6'd10);
    step();
    in_valid = 1'b0;
    check("full_ignored_occ", {29'h0, occupancy}, 32'd4);
    rs_ready = 1'b1;
    step();
    rs_ready = 1'b0;
    check("full_pop_occ3", {29'h0, occupancy}, 32'd3);
    check("full_pop_in_ready", {31'h0, in_ready}, 32'h1);
    rs_ready = 1'b1;
    step();
    step();
    step();
    rs_ready = 1'b0;
    check("full_drain_occ", {29'h0, occupancy}, 32'd0);

    // Continuous push/pop at count 2 across pointer wrap.
    push_uop(6'd20);
    push_uop(6'd21);
    rs_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_uop   = mk_uop(6'(22 + i));
      exp_q.push_back(mk_uop(6'(22 + i)));
      step();
      check("steady_occ2", {29'h0, occupancy}, 32'd2);
    end
    in_valid = 1'b0;
    step();
    step();
    rs_ready = 1'b0;
    check("steady_drain_occ", {29'h0, occupancy}, 32'd0);

    // Flush with three buffered uops and a uop arriving.
    push_uop(6'd40);
    push_uop(6'd41);
    push_uop(6'd42);
    check("preflush_occ3", {29'h0, occupancy}, 32'd3);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_uop   = mk_uop(6'd43);
    exp_q.delete();
    #1;
    check("flush_rs_valid", {31'h0, rs_valid}, 32'h0);
    check("flush_in_ready", {31'h0, in_ready}, 32'h0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("postflush_occ", {29'h0, occupancy}, 32'd0);
    check("postflush_rs_valid", {31'h0, rs_valid}, 32'h0);

    // Bypass / latency from empty.
    step();
    in_valid = 1'b1;
    in_uop   = mk_uop(6'd7);
    rs_ready = 1'b1;
    exp_q.push_back(mk_uop(6'd7));
    #1;
`ifdef BR_DISPATCH_BYPASS_EN
    check("bypass_rs_valid", {31'h0, rs_valid}, 32'h1);
    check("bypass_rob_id", {26'h0, rs_uop.rob_id}, 32'd7);
    step();
    in_valid = 1'b0;
    check("bypass_occ", {29'h0, occupancy}, 32'd0);
`else
    check("nobypass_rs_valid_now", {31'h0, rs_valid}, 32'h0);
    step();
    in_valid = 1'b0;
    check("nobypass_rs_valid_next", {31'h0, rs_valid}, 32'h1);
    check("nobypass_rob_id", {26'h0, rs_uop.rob_id}, 32'd7);
    step();
    check("nobypass_occ", {29'h0, occupancy}, 32'd0);
`endif
    rs_ready = 1'b0;
    step();

    // Async reset mid-cycle with buffered uops.
    push_uop(6'd50);
    push_uop(6'd51);
    check("prereset_occ2", {29'h0, occupancy}, 32'd2);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("areset_in_ready", {31'h0, in_ready}, 32'h1);
    check("areset_rs_valid", {31'h0, rs_valid}, 32'h0);
    check("areset_occ", {29'h0, occupancy}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("postreset_occ", {29'h0, occupancy}, 32'd0);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
